// File: rtl/echo_fir_mac_pkg.sv
// echo_pkg: shared types and defaults for the echo canceller FIR estimator.
//   state_e  : FSM states of echo_fir_mac (IDLE, MAC, ROUND, OUT)
//   DATA_W / COEF_W / ACC_W : default sample, coefficient and accumulator widths
//   addr_w() : tap-index width for a given filter length
package echo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int ACC_W  = 40;

  function automatic int addr_w(input int taps);
    return (taps <= 2) ? 1 : $clog2(taps);
  endfunction

endpackage

// File: rtl/echo_mac_unit.sv
// echo_mac_unit: signed multiply with a registered accumulator.
//   clk, rst_n : clock, async active-low reset (clears the accumulator)
//   clr        : load zero into the accumulator (wins over en)
//   en         : add a*b (full precision, sign-extended) into the accumulator
//   a, b       : signed operands
//   acc        : registered accumulator value
module echo_mac_unit
  import echo_pkg::*;
#(
  parameter int A_W    = echo_pkg::DATA_W,
  parameter int B_W    = echo_pkg::COEF_W,
  parameter int ACC_W  = echo_pkg::ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [A_W+B_W-1:0] prod;
  logic signed [ACC_W-1:0]   acc_d, acc_q;

  always_comb begin
    prod  = a * b;
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q + ACC_W'(prod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/echo_fir_mac.sv
// echo_fir_mac: sequential FIR echo estimator, one tap per cycle.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : far-end sample handshake (in_sample)
//   coef_we/addr/wdata  : coefficient bank write port, accepted in any state
//   out_valid/out_ready : estimate handshake (out_estimate, held until taken)
//   busy                : FSM not idle
// Build option: define ECHO_FIR_SAT_EN to clamp the estimate to the DATA_W
// range instead of wrapping to its low DATA_W bits.
module echo_fir_mac
  import echo_pkg::*;
#(
  parameter int DATA_W    = echo_pkg::DATA_W,
  parameter int COEF_W    = echo_pkg::COEF_W,
  parameter int TAPS      = 4,
  parameter int ACC_W     = echo_pkg::ACC_W,
  parameter int OUT_SHIFT = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_sample,
  input  logic                       coef_we,
  input  logic [addr_w(TAPS)-1:0]    coef_addr,
  input  logic [COEF_W-1:0]          coef_wdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_estimate,
  output logic                       busy
);

  localparam int AW = addr_w(TAPS);

  // Half-LSB of the output scale, added before the arithmetic shift.
  localparam logic signed [ACC_W-1:0] RND_K = ACC_W'(1) << (OUT_SHIFT - 1);

  state_e                         state_d, state_q;
  logic [AW-1:0]                  cnt_d, cnt_q;
  logic [TAPS-1:0][DATA_W-1:0]    x_d, x_q;
  logic [TAPS-1:0][COEF_W-1:0]    h_d, h_q;
  logic [DATA_W-1:0]              est_d, est_q;
  logic                           ov_d, ov_q;
  logic                           mac_clr, mac_en;
  logic signed [ACC_W-1:0]        acc;

`ifdef ECHO_FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] EST_MAX = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] EST_MIN = -(ACC_W'(1) << (DATA_W - 1));
  logic signed [ACC_W-1:0] r_full;
`endif

  echo_mac_unit #(
    .A_W   (DATA_W),
    .B_W   (COEF_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     ($signed(x_q[cnt_q])),
    .b     ($signed(h_q[cnt_q])),
    .acc   (acc)
  );

  // Coefficient bank: a write lands at the next edge, so a MAC read of the
  // same tap in the write cycle still sees the old value. Addresses past the
  // last tap match no entry and are dropped.
  always_comb begin
    h_d = h_q;
    for (int k = 0; k < TAPS; k++) begin
      if (coef_we && coef_addr == AW'(k)) h_d[k] = coef_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    est_d   = est_q;
    ov_d    = ov_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
`ifdef ECHO_FIR_SAT_EN
    r_full  = (acc + RND_K) >>> OUT_SHIFT;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = {x_q[TAPS-2:0], in_sample};
          cnt_d   = '0;
          mac_clr = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == AW'(TAPS - 1)) state_d = ROUND;
      end
      ROUND: begin
`ifdef ECHO_FIR_SAT_EN
        if (r_full > EST_MAX)      est_d = EST_MAX[DATA_W-1:0];
        else if (r_full < EST_MIN) est_d = EST_MIN[DATA_W-1:0];
        else                       est_d = r_full[DATA_W-1:0];
`else
        est_d = DATA_W'((acc + RND_K) >>> OUT_SHIFT);
`endif
        ov_d    = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      h_q     <= '0;
      est_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      h_q     <= h_d;
      est_q   <= est_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign out_valid    = ov_q;
  assign out_estimate = est_q;

endmodule

// File: tb/tb_echo_fir_mac.sv
// tb_echo_fir_mac: directed self-checking bench for echo_fir_mac
// (TAPS=4, OUT_SHIFT=15, DATA_W=COEF_W=16). Inputs change on the falling
// edge, outputs are sampled on the falling edge.
module tb_echo_fir_mac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_sample = '0;
  logic        coef_we = 1'b0;
  logic [1:0]  coef_addr = '0;
  logic [15:0] coef_wdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_estimate;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  echo_fir_mac #(
    .DATA_W(16), .COEF_W(16), .TAPS(4), .ACC_W(40), .OUT_SHIFT(15)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sample    (in_sample),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_wdata   (coef_wdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_estimate (out_estimate),
    .busy         (busy)
  );

  task apply_reset;
    rst_n = 1'b0; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task write_coef(input logic [1:0] a, input logic [15:0] d);
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    @(posedge clk);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // Sends one sample, optionally writes a coefficient during the first MAC
  // cycle, and waits (bounded) for out_valid. Leaves the estimate untaken.
  task send(input logic [15:0] s, input bit wr, input logic [1:0] wa,
            input logic [15:0] wd, output logic [15:0] est, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    in_valid = 1'b1; in_sample = s;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    coef_we = wr; coef_addr = wa; coef_wdata = wd;
    while (!out_valid && lat < 50) begin
      @(posedge clk); lat++;
      @(negedge clk); coef_we = 1'b0;
    end
    coef_we = 1'b0;
    est = out_estimate;
  endtask

  task take;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task test_reset;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_estimate !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b busy=%b est=%0d expected 0 0 0",
               out_valid, busy, out_estimate);
    end
    apply_reset;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task test_single_tap;
    logic [15:0] est; int lat;
    apply_reset;
    write_coef(2'd0, 16'd16384);
    send(16'd1000, 1'b0, 2'd0, 16'd0, est, lat);
    checks++;
    if (est !== 16'd500) begin
      errors++; $display("FAIL single_tap_est: got %0d expected 500", $signed(est));
    end
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL single_tap_latency: got %0d expected 5", lat);
    end
    take;
  endtask

  task test_impulse;
    logic [15:0] est; int lat;
    logic [15:0] smp [4];
    logic [15:0] exp_e [4];
    smp   = '{16'd32767, 16'd0, 16'd0, 16'd0};
    exp_e = '{16'd16384, 16'd8192, 16'd4096, 16'd2048};
    apply_reset;
    write_coef(2'd0, 16'd16384);
    write_coef(2'd1, 16'd8192);
    write_coef(2'd2, 16'd4096);
    write_coef(2'd3, 16'd2048);
    for (int i = 0; i < 4; i++) begin
      send(smp[i], 1'b0, 2'd0, 16'd0, est, lat);
      checks++;
      if (est !== exp_e[i]) begin
        errors++;
        $display("FAIL impulse_%0d: got %0d expected %0d", i, $signed(est), $signed(exp_e[i]));
      end
      take;
    end
  endtask

  task test_backpressure;
    logic [15:0] est; int lat;
    apply_reset;
    write_coef(2'd0, 16'd16384);
    send(16'd1000, 1'b0, 2'd0, 16'd0, est, lat);
    in_valid = 1'b1; in_sample = 16'd77;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_estimate !== 16'd500 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold_%0d: got valid=%b est=%0d in_ready=%b expected 1 500 0",
                 i, out_valid, $signed(out_estimate), in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_handshake: got valid=%b busy=%b in_ready=%b expected 0 0 1",
               out_valid, busy, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL backpressure_accept77: got busy=%b expected 1", busy);
    end
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
    checks++;
    if (out_estimate !== 16'd39 || lat !== 5) begin
      errors++;
      $display("FAIL backpressure_est77: got est=%0d lat=%0d expected 39 5",
               $signed(out_estimate), lat);
    end
    take;
  endtask

  task test_overflow;
    logic [15:0] est; int lat;
    logic [15:0] e [4];
    logic [15:0] exp1, exp2, exp4;
    exp1 = 16'd32766;
`ifdef ECHO_FIR_SAT_EN
    exp2 = 16'd32767;
    exp4 = 16'd32767;
`else
    exp2 = 16'hFFFC;
    exp4 = 16'hFFF8;
`endif
    apply_reset;
    for (int k = 0; k < 4; k++) write_coef(2'(k), 16'd32767);
    for (int i = 0; i < 4; i++) begin
      send(16'd32767, 1'b0, 2'd0, 16'd0, est, lat);
      e[i] = est;
      take;
    end
    checks++;
    if (e[0] !== exp1) begin
      errors++; $display("FAIL overflow_1st: got %0d expected %0d", $signed(e[0]), $signed(exp1));
    end
    checks++;
    if (e[1] !== exp2) begin
      errors++; $display("FAIL overflow_2nd: got %0d expected %0d", $signed(e[1]), $signed(exp2));
    end
    checks++;
    if (e[3] !== exp4) begin
      errors++; $display("FAIL overflow_4th: got %0d expected %0d", $signed(e[3]), $signed(exp4));
    end
  endtask

  task test_coef_during_mac;
    logic [15:0] est; int lat;
    apply_reset;
    for (int i = 0; i < 3; i++) begin
      send(16'd1000, 1'b0, 2'd0, 16'd0, est, lat);
      take;
    end
    checks++;
    if (est !== 16'd0) begin
      errors++; $display("FAIL coef_zero_bank: got %0d expected 0", $signed(est));
    end
    // h[0] written in the cycle MAC reads it: old (zero) value is used
    send(16'd1000, 1'b1, 2'd0, 16'd16384, est, lat);
    checks++;
    if (est !== 16'd0) begin
      errors++; $display("FAIL coef_same_tap_old: got %0d expected 0", $signed(est));
    end
    take;
    write_coef(2'd0, 16'd0);
    // h[3] written before MAC reaches it: new value is used
    send(16'd1000, 1'b1, 2'd3, 16'd16384, est, lat);
    checks++;
    if (est !== 16'd500) begin
      errors++; $display("FAIL coef_later_tap_new: got %0d expected 500", $signed(est));
    end
    take;
  endtask

  task test_reset_mid;
    logic [15:0] est; int lat;
    apply_reset;
    write_coef(2'd0, 16'd16384);
    in_valid = 1'b1; in_sample = 16'd1000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_mac: got valid=%b busy=%b in_ready=%b expected 0 0 1",
               out_valid, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    write_coef(2'd0, 16'd16384);
    send(16'd1000, 1'b0, 2'd0, 16'd0, est, lat);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_estimate !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_out: got valid=%b est=%0d expected 0 0",
               out_valid, $signed(out_estimate));
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
    send(16'd1000, 1'b0, 2'd0, 16'd0, est, lat);
    checks++;
    if (est !== 16'd0 || lat !== 5) begin
      errors++;
      $display("FAIL reset_cleared_coefs: got est=%0d lat=%0d expected 0 5", $signed(est), lat);
    end
    take;
  endtask

  initial begin
    test_reset;
    test_single_tap;
    test_impulse;
    test_backpressure;
    test_overflow;
    test_coef_during_mac;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
